icache_resp: RTL and testbench
==============================

Name: icache_resp

Overview:
- Instruction-cache responder that sits on the far side of the fetch unit's icache interface.
- Accepts word fetch requests and returns instructions strictly in request order.
- Honours fetch flushes by discarding responses to requests that have been squashed.
- Direct-mapped and blocking. Misses are serviced by a single line-fill burst on a simple memory read port.

Parameters:
SETS, 64, number of lines; power of 2, >= 2
LINE_WORDS, 4, 32-bit words per line; power of 2, >= 2

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
fetch_ic_req  in  1  request valid
fetch_ic_addr  in  30  word address [31:2]
fetch_ic_flush  in  1  squash all outstanding requests
icache_ready  out  1  request accepted this cycle if fetch_ic_req=1
icache_valid  out  1  response valid
icache_error  out  1  response carries a bus error
icache_data  out  32  instruction word
mem_req  out  1  line read request
mem_addr  out  30  line base word address; offset bits are zero
mem_ready  in  1  memory accepts mem_req
mem_valid  in  1  fill beat valid
mem_error  in  1  fill beat error
mem_data  in  32  fill beat data

Behaviour:
- Address split. OFF = log2(LINE_WORDS) low bits of fetch_ic_addr. IDX = next log2(SETS) bits. TAG = remaining upper bits.
- Storage. Per set: valid bit, tag and LINE_WORDS data words, held in flops. Also a one-entry lookup stage S1 holding {valid, addr}.
- Reset (rst=0, async):
  - all line valid bits cleared; S1 invalid; state RUN; fill counter 0.
  - outputs: icache_ready=1, icache_valid=0, icache_error=0, icache_data=0, mem_req=0.
- Accept. A request is accepted at cycle T when fetch_ic_req & icache_ready. The address is captured into S1 at the T edge.
- Hit, state RUN:
  - At T+1, S1 is compared against the indexed tag.
  - On hit: icache_valid=1, icache_error=0, icache_data = line word[OFF], all combinational from S1.
  - icache_ready = (state==RUN) & ~(S1.valid & miss).
  - Back-to-back hits sustain 1 response per cycle.
- Miss:
  - At T+1: icache_ready=0 and icache_valid=0. The state moves to MREQ at the edge.
  - MREQ: mem_req = ~fetch_ic_flush; mem_addr = line base of S1.addr. On mem_req & mem_ready, go to FILL.
  - FILL: beats arrive in order, word 0 first. Each mem_valid writes the fill buffer and increments the counter. Any mem_error sets a sticky err flag.
  - After beat LINE_WORDS-1, go to RESP. If err=0, install the line (data, tag, valid=1). If err=1, leave the set unchanged.
  - RESP (1 cycle):
    - icache_valid=1; icache_error=err; icache_data = fill word[OFF], or 0 if err.
    - Then go to RUN with S1 cleared; icache_ready returns to 1 the following cycle.
- Flush (fetch_ic_flush=1 in cycle F):
  - Any response driven in F itself (hit or RESP) is still driven. Fetch decides whether to consume it.
  - No response is ever driven after F for any request accepted at or before F.
  - RUN: S1 cleared at the F edge, so a miss in F never enters MREQ.
  - MREQ: mem_req is suppressed in F. Return to RUN; no memory request is issued.
  - FILL: set a kill flag. The burst completes and the line is installed if err=0. RESP is replaced by a silent return to RUN.
  - Flush in the same cycle as fetch_ic_req: no request is accepted in F. The fetch unit never drives both.
- Ordering: at most one request outstanding past S1, so responses are in-order by construction.
- Unexpected mem_valid outside FILL is ignored.

Optional Feature:
- Macro: ICACHE_STATS_EN.
- Defined:
  - adds outputs icache_hit_cnt[31:0] and icache_miss_cnt[31:0].
  - hit_cnt increments on each S1 hit response; miss_cnt increments on each MREQ entry.
  - both counters reset to 0 and wrap at 2^32.
- Undefined: the ports and counters are absent, with no other behaviour change.

Test Plan:
1. Cold miss: after reset, req addr 0x04000000 -> mem_req with mem_addr=0x04000000 at T+2; return beats 0x11,0x22,0x33,0x44 -> icache_valid with data 0x11, error 0, in the cycle after the 4th beat.
2. Hit streaming: then reqs 0x04000001, 0x04000002, 0x04000003 on consecutive cycles -> icache_valid on 3 consecutive cycles with data 0x22,0x33,0x44; ready stays 1.
3. Conflict miss: req 0x04000100 (same IDX, different TAG with defaults) -> refill. A re-request of 0x04000000 then misses again.
4. Flush during FILL: miss on 0x05000000, fetch_ic_flush after beat 1 -> no icache_valid for it. A later req 0x05000000 hits with no mem_req.
5. Error fill: mem_error on beat 2 -> icache_valid=1, icache_error=1, data 0. Line not installed; a re-request raises mem_req again.
6. Reset mid-FILL (rst=0 at beat 2) -> outputs return to reset values immediately. A subsequent req to a previously cached line misses.

Source files
------------

// File: rtl/icache_resp.sv
// icache_resp: in-order, blocking, direct-mapped icache responder with line-fill on a memory read port.
// Optional ICACHE_STATS_EN adds hit/miss counter outputs.
module icache_resp #(
  parameter int SETS = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_ic_req,
  input  logic [29:0] fetch_ic_addr,
  input  logic        fetch_ic_flush,
  output logic        icache_ready,
  output logic        icache_valid,
  output logic        icache_error,
  output logic [31:0] icache_data,
  output logic        mem_req,
  output logic [29:0] mem_addr,
  input  logic        mem_ready,
  input  logic        mem_valid,
  input  logic        mem_error,
  input  logic [31:0] mem_data
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] icache_hit_cnt,
  output logic [31:0] icache_miss_cnt
`endif
);
  localparam int OW = $clog2(LINE_WORDS);
  localparam int IW = $clog2(SETS);
  localparam int TW = 30 - OW - IW;
  typedef enum logic [1:0] {RUN, MREQ, FILL, RESP} state_t;
  state_t state_q, state_d;
  logic s1_v_q, s1_v_d;
  logic [29:0] s1_a_q, s1_a_d;
  logic [OW-1:0] cnt_q, cnt_d;
  logic err_q, err_d, kill_q, kill_d, install;
  logic [SETS-1:0] valid_q;
  logic [TW-1:0] tag_q [SETS];
  logic [31:0] data_q [SETS][LINE_WORDS];
  logic [31:0] buf_q [LINE_WORDS];
  logic [OW-1:0] s1_off;
  logic [IW-1:0] s1_idx;
  logic [TW-1:0] s1_tag;
  logic hit, run_hit, acc;
  assign s1_off = s1_a_q[OW-1:0];
  assign s1_idx = s1_a_q[OW+:IW];
  assign s1_tag = s1_a_q[29:OW+IW];
  assign hit = s1_v_q & valid_q[s1_idx] & (tag_q[s1_idx] == s1_tag);
  assign run_hit = (state_q == RUN) & hit;
  assign icache_ready = (state_q == RUN) & ~(s1_v_q & ~hit);
  // a flush cycle never accepts, even if fetch also raised a request
  assign acc = fetch_ic_req & icache_ready & ~fetch_ic_flush;
  assign icache_valid = run_hit | (state_q == RESP);
  assign icache_error = (state_q == RESP) & err_q;
  assign icache_data = run_hit ? data_q[s1_idx][s1_off] :
                       ((state_q == RESP) & ~err_q) ? buf_q[s1_off] : 32'd0;
  assign mem_addr = {s1_a_q[29:OW], {OW{1'b0}}};
  always_comb begin
    state_d = state_q;
    s1_v_d = s1_v_q;
    s1_a_d = s1_a_q;
    cnt_d = cnt_q;
    err_d = err_q;
    kill_d = kill_q;
    install = 1'b0;
    mem_req = 1'b0;
    case (state_q)
      RUN: begin
        if (fetch_ic_flush) s1_v_d = 1'b0;
        else if (s1_v_q & ~hit) state_d = MREQ;
        else begin
          s1_v_d = acc;
          s1_a_d = fetch_ic_addr;
        end
      end
      MREQ: begin
        mem_req = ~fetch_ic_flush;
        if (fetch_ic_flush) begin
          state_d = RUN;
          s1_v_d = 1'b0;
        end else if (mem_ready) begin
          state_d = FILL;
          cnt_d = '0;
          err_d = 1'b0;
          kill_d = 1'b0;
        end
      end
      FILL: begin
        kill_d = kill_q | fetch_ic_flush;
        if (mem_valid) begin
          cnt_d = cnt_q + 1'b1;
          err_d = err_q | mem_error;
          // last beat: install from buffer plus this beat, then respond unless squashed
          if (cnt_q == {OW{1'b1}}) begin
            install = ~err_d;
            state_d = kill_d ? RUN : RESP;
            s1_v_d = ~kill_d;
          end
        end
      end
      default: begin
        state_d = RUN;
        s1_v_d = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      s1_v_q <= 1'b0;
      s1_a_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
      kill_q <= 1'b0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      s1_v_q <= s1_v_d;
      s1_a_q <= s1_a_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      kill_q <= kill_d;
      if (install) valid_q[s1_idx] <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if ((state_q == FILL) && mem_valid) buf_q[cnt_q] <= mem_data;
    if (install) begin
      tag_q[s1_idx] <= s1_tag;
      for (int w = 0; w < LINE_WORDS; w++)
        data_q[s1_idx][w] <= (w == LINE_WORDS - 1) ? mem_data : buf_q[w];
    end
  end
`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      icache_hit_cnt <= '0;
      icache_miss_cnt <= '0;
    end else begin
      if (run_hit) icache_hit_cnt <= icache_hit_cnt + 32'd1;
      if ((state_q != MREQ) && (state_d == MREQ)) icache_miss_cnt <= icache_miss_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_icache_resp.sv
// tb_icache_resp: directed bench for icache_resp covering miss, hit stream, conflict, flush, error and reset.
module tb_icache_resp;
  logic clk, rst, fetch_ic_req, fetch_ic_flush, mem_ready, mem_valid, mem_error;
  logic [29:0] fetch_ic_addr, mem_addr;
  logic [31:0] mem_data, icache_data;
  logic icache_ready, icache_valid, icache_error, mem_req;
  int checks = 0;
  int errors = 0;
  localparam logic [29:0] A0 = 30'h04000000, B0 = 30'h04000100, C0 = 30'h05000000, D0 = 30'h06000000;
  icache_resp dut (
    .clk(clk), .rst(rst), .fetch_ic_req(fetch_ic_req), .fetch_ic_addr(fetch_ic_addr),
    .fetch_ic_flush(fetch_ic_flush), .icache_ready(icache_ready), .icache_valid(icache_valid),
    .icache_error(icache_error), .icache_data(icache_data), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_valid(mem_valid), .mem_error(mem_error), .mem_data(mem_data)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input logic rq, input logic [29:0] a, input logic fl, input logic mr,
                     input logic mv, input logic me, input logic [31:0] md);
    @(negedge clk);
    fetch_ic_req = rq;
    fetch_ic_addr = a;
    fetch_ic_flush = fl;
    mem_ready = mr;
    mem_valid = mv;
    mem_error = me;
    mem_data = md;
    #1;
  endtask
  task automatic idle();
    cyc(1'b0, 30'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask
  task automatic beat(input logic [31:0] md, input logic me);
    cyc(1'b0, 30'd0, 1'b0, 1'b0, 1'b1, me, md);
    chk("fill_quiet", {31'd0, icache_valid}, 32'd0);
  endtask
  task automatic miss_start(input string tag, input logic [29:0] a);
    cyc(1'b1, a, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    chk({tag, "_accept"}, {31'd0, icache_ready}, 32'd1);
    idle();
    chk({tag, "_miss_ready"}, {31'd0, icache_ready}, 32'd0);
    chk({tag, "_miss_valid"}, {31'd0, icache_valid}, 32'd0);
    cyc(1'b0, 30'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    chk({tag, "_mem_req"}, {31'd0, mem_req}, 32'd1);
    chk({tag, "_mem_addr"}, {2'd0, mem_addr}, {2'd0, a});
  endtask
  initial begin
    rst = 1'b0;
    idle();
    chk("rst_ready", {31'd0, icache_ready}, 32'd1);
    chk("rst_valid", {31'd0, icache_valid}, 32'd0);
    chk("rst_error", {31'd0, icache_error}, 32'd0);
    chk("rst_data", icache_data, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    rst = 1'b1;
    // cold miss
    miss_start("cold", A0);
    beat(32'h11, 1'b0);
    beat(32'h22, 1'b0);
    beat(32'h33, 1'b0);
    beat(32'h44, 1'b0);
    idle();
    chk("cold_valid", {31'd0, icache_valid}, 32'd1);
    chk("cold_error", {31'd0, icache_error}, 32'd0);
    chk("cold_data", icache_data, 32'h11);
    chk("cold_resp_ready", {31'd0, icache_ready}, 32'd0);
    // hit streaming
    cyc(1'b1, A0 + 30'd1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("hs_ready0", {31'd0, icache_ready}, 32'd1);
    chk("hs_valid0", {31'd0, icache_valid}, 32'd0);
    cyc(1'b1, A0 + 30'd2, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("hs_valid1", {31'd0, icache_valid}, 32'd1);
    chk("hs_data1", icache_data, 32'h22);
    chk("hs_ready1", {31'd0, icache_ready}, 32'd1);
    cyc(1'b1, A0 + 30'd3, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("hs_valid2", {31'd0, icache_valid}, 32'd1);
    chk("hs_data2", icache_data, 32'h33);
    chk("hs_ready2", {31'd0, icache_ready}, 32'd1);
    idle();
    chk("hs_valid3", {31'd0, icache_valid}, 32'd1);
    chk("hs_data3", icache_data, 32'h44);
    idle();
    chk("hs_drain", {31'd0, icache_valid}, 32'd0);
    // conflict miss, then re-request of evicted line squashed in MREQ
    miss_start("conf", B0);
    beat(32'hA1, 1'b0);
    beat(32'hA2, 1'b0);
    beat(32'hA3, 1'b0);
    beat(32'hA4, 1'b0);
    idle();
    chk("conf_valid", {31'd0, icache_valid}, 32'd1);
    chk("conf_data", icache_data, 32'hA1);
    cyc(1'b1, A0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("evict_accept", {31'd0, icache_ready}, 32'd1);
    idle();
    chk("evict_miss_ready", {31'd0, icache_ready}, 32'd0);
    chk("evict_miss_valid", {31'd0, icache_valid}, 32'd0);
    cyc(1'b0, 30'd0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    chk("mreq_flush_req", {31'd0, mem_req}, 32'd0);
    idle();
    chk("mreq_flush_ready", {31'd0, icache_ready}, 32'd1);
    chk("mreq_flush_valid", {31'd0, icache_valid}, 32'd0);
    chk("mreq_flush_req2", {31'd0, mem_req}, 32'd0);
    // flush during fill
    miss_start("kill", C0);
    beat(32'h51, 1'b0);
    beat(32'h52, 1'b0);
    cyc(1'b0, 30'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("kill_flush_valid", {31'd0, icache_valid}, 32'd0);
    beat(32'h53, 1'b0);
    beat(32'h54, 1'b0);
    idle();
    chk("kill_no_resp", {31'd0, icache_valid}, 32'd0);
    chk("kill_ready", {31'd0, icache_ready}, 32'd1);
    cyc(1'b1, C0 + 30'd2, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("kill_hit_accept", {31'd0, icache_ready}, 32'd1);
    idle();
    chk("kill_hit_valid", {31'd0, icache_valid}, 32'd1);
    chk("kill_hit_data", icache_data, 32'h53);
    chk("kill_hit_noreq", {31'd0, mem_req}, 32'd0);
    // error fill
    miss_start("err", D0);
    beat(32'h61, 1'b0);
    beat(32'h62, 1'b0);
    beat(32'h63, 1'b1);
    beat(32'h64, 1'b0);
    idle();
    chk("err_valid", {31'd0, icache_valid}, 32'd1);
    chk("err_error", {31'd0, icache_error}, 32'd1);
    chk("err_data", icache_data, 32'd0);
    cyc(1'b1, C0 + 30'd1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("err_keep_accept", {31'd0, icache_ready}, 32'd1);
    cyc(1'b1, D0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("err_keep_valid", {31'd0, icache_valid}, 32'd1);
    chk("err_keep_data", icache_data, 32'h52);
    chk("err_redo_accept", {31'd0, icache_ready}, 32'd1);
    idle();
    chk("err_redo_ready", {31'd0, icache_ready}, 32'd0);
    chk("err_redo_valid", {31'd0, icache_valid}, 32'd0);
    idle();
    chk("err_redo_mem_req", {31'd0, mem_req}, 32'd1);
    chk("err_redo_mem_addr", {2'd0, mem_addr}, {2'd0, D0});
    // reset in the middle of a fill
    cyc(1'b0, 30'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    beat(32'h71, 1'b0);
    beat(32'h72, 1'b0);
    cyc(1'b0, 30'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h73);
    rst = 1'b0;
    #1;
    chk("mrst_ready", {31'd0, icache_ready}, 32'd1);
    chk("mrst_valid", {31'd0, icache_valid}, 32'd0);
    chk("mrst_error", {31'd0, icache_error}, 32'd0);
    chk("mrst_data", icache_data, 32'd0);
    chk("mrst_mem_req", {31'd0, mem_req}, 32'd0);
    idle();
    rst = 1'b1;
    cyc(1'b1, C0 + 30'd1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("post_rst_accept", {31'd0, icache_ready}, 32'd1);
    idle();
    chk("post_rst_miss_valid", {31'd0, icache_valid}, 32'd0);
    chk("post_rst_miss_ready", {31'd0, icache_ready}, 32'd0);
    idle();
    chk("post_rst_mem_req", {31'd0, mem_req}, 32'd1);
    chk("post_rst_mem_addr", {2'd0, mem_addr}, {2'd0, C0});
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
